// File: rtl/sgdmac_desc_fetch_if.sv
// ---------------------------------------------------------------------------
// sgdmac_desc_fetch_if
//
// Bundles the bus-side signals of the descriptor fetch engine:
//   - AXI read address channel (ar*): descriptor read requests.
//   - AXI read data channel (r*): descriptor words returning from memory.
//   - Descriptor output port (desc_*): decoded descriptor handed to the
//     copy engine with a valid/ready handshake.
//
// Signal names keep the _o/_i suffixes as seen from the fetch engine, so the
// "master" modport is the fetch engine and the "slave" modport is whatever
// sits on the other side (AXI arbiter/memory plus copy engine).
// ---------------------------------------------------------------------------
interface sgdmac_desc_fetch_if;
  // AXI AR channel
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [3:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o;
  logic        arready_i;

  // AXI R channel
  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i;
  logic        rvalid_i;
  logic        rready_o;

  // Descriptor output port
  logic        desc_valid_o;
  logic        desc_ready_i;
  logic [31:0] desc_src_o;
  logic [31:0] desc_dst_o;
  logic [15:0] desc_len_o;
  logic        desc_last_o;

  modport master (
    output arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
    input  arready_i,
    input  rid_i, rdata_i, rresp_i, rlast_i, rvalid_i,
    output rready_o,
    output desc_valid_o, desc_src_o, desc_dst_o, desc_len_o, desc_last_o,
    input  desc_ready_i
  );

  modport slave (
    input  arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o,
    output arready_i,
    output rid_i, rdata_i, rresp_i, rlast_i, rvalid_i,
    input  rready_o,
    input  desc_valid_o, desc_src_o, desc_dst_o, desc_len_o, desc_last_o,
    output desc_ready_i
  );
endinterface

// File: rtl/sgdmac_desc_fetch.sv
// ---------------------------------------------------------------------------
// sgdmac_desc_fetch
//
// Descriptor fetch engine for the scatter-gather DMA. Starting from a head
// pointer it reads each 16-byte descriptor as one 4-beat INCR burst, presents
// {src, dst, len, last} to the copy engine, and follows the next pointer
// until it reads a null next pointer.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   start_i     one-cycle start pulse, honoured only when idle
//   head_ptr_i  first descriptor address (low 4 bits ignored)
//   busy_o      engine is working on a chain
//   done_o      one-cycle pulse when the last descriptor is accepted
//   err_o       sticky read error, cleared by the next accepted start
//   bus         AXI AR/R channels and descriptor output port (master side)
//
// Parameter:
//   DESC_ARID   AXI ID used for every descriptor read
// ---------------------------------------------------------------------------
module sgdmac_desc_fetch #(
  parameter logic [3:0] DESC_ARID = 4'h1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [31:0]                head_ptr_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  sgdmac_desc_fetch_if.master        bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AR    = 3'd1;
  localparam logic [2:0] S_R     = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]  state;
  logic [31:0] cur_ptr;
  logic [1:0]  cnt;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        last;
  logic [31:0] next_ptr;
  logic        done;
  logic        err;
  logic        beat_err;

  // A beat is bad if the slave flags an error, or if rlast does not land
  // exactly on the fourth beat of the burst.
  always_comb begin
    beat_err = 1'b0;
    if (bus.rresp_i != 2'b00)
      beat_err = 1'b1;
    else if (bus.rlast_i && (cnt != 2'd3))
      beat_err = 1'b1;
    else if (!bus.rlast_i && (cnt == 2'd3))
      beat_err = 1'b1;
  end

  // Main sequencer. done is a single-cycle pulse and defaults low every
  // cycle; the descriptor words are captured straight off the R channel
  // and only become visible downstream once the state reaches S_OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur_ptr  <= 32'h0;
      cnt      <= 2'd0;
      src      <= 32'h0;
      dst      <= 32'h0;
      len      <= 16'h0;
      last     <= 1'b0;
      next_ptr <= 32'h0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            cur_ptr <= head_ptr_i & ~32'hF;
            err     <= 1'b0;
            state   <= S_AR;
          end
        end

        S_AR: begin
          if (bus.arready_i) begin
            cnt   <= 2'd0;
            state <= S_R;
          end
        end

        S_R: begin
          if (bus.rvalid_i) begin
            case (cnt)
              2'd0: src <= bus.rdata_i;
              2'd1: dst <= bus.rdata_i;
              2'd2: len <= bus.rdata_i[15:0];
              default: begin
                next_ptr <= bus.rdata_i;
                last     <= (bus.rdata_i == 32'h0);
              end
            endcase
            cnt <= cnt + 2'd1;
            // An error beat that already closes the burst can return to idle
            // directly; otherwise the rest of the burst must be swallowed.
            if (beat_err) begin
              err   <= 1'b1;
              state <= bus.rlast_i ? S_IDLE : S_DRAIN;
            end else if (cnt == 2'd3) begin
              state <= S_OUT;
            end
          end
        end

        S_DRAIN: begin
          if (bus.rvalid_i && bus.rlast_i)
            state <= S_IDLE;
        end

        S_OUT: begin
          if (bus.desc_ready_i) begin
            if (last) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              cur_ptr <= next_ptr & ~32'hF;
              state   <= S_AR;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode directly from the registered state, so they
  // are glitch-free and all drop to zero under reset.
  assign bus.arvalid_o    = (state == S_AR);
  assign bus.rready_o     = (state == S_R) || (state == S_DRAIN);
  assign bus.desc_valid_o = (state == S_OUT);
  assign busy_o           = (state != S_IDLE);
  assign done_o           = done;
  assign err_o            = err;

  assign bus.arid_o    = DESC_ARID;
  assign bus.araddr_o  = cur_ptr;
  assign bus.arlen_o   = 4'd3;
  assign bus.arsize_o  = 3'd2;
  assign bus.arburst_o = 2'b01;

  assign bus.desc_src_o  = src;
  assign bus.desc_dst_o  = dst;
  assign bus.desc_len_o  = len;
  assign bus.desc_last_o = last;

endmodule

// File: doc/sgdmac_desc_fetch.md
# sgdmac_desc_fetch

Descriptor fetch engine for the scatter-gather DMA controller. Given a head descriptor pointer from the APB register block, it reads each 16-byte descriptor over the AXI AR/R channels as a single 4-beat INCR burst. It hands the decoded descriptor (source, destination, length) to the copy engine over a valid/ready port, then follows the next pointer until it reaches a null pointer. It sits directly upstream of the DMA data-move engine and shares the AXI read port with it through an external arbiter.

## Interface
- DESC_ARID, default 4'h1: AXI ID driven on arid_o for all descriptor reads.
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start pulse; sampled only in IDLE
- head_ptr_i  in  32  first descriptor address; bits [3:0] ignored (forced to 0)
- busy_o  out  1  high from the cycle after an accepted start until return to IDLE
- done_o  out  1  one-cycle pulse when the last descriptor is accepted downstream
- err_o  out  1  sticky error; cleared by the next accepted start_i
- desc_valid_o  out  1  descriptor available
- desc_ready_i  in  1  copy engine accepts the descriptor
- desc_src_o  out  32  word 0 of the descriptor
- desc_dst_o  out  32  word 1 of the descriptor
- desc_len_o  out  16  word 2 bits [15:0], byte count; bits [31:16] ignored
- desc_last_o  out  1  1 when word 3 (next pointer) equals 0
- arid_o / araddr_o / arlen_o / arsize_o / arburst_o  out  4/32/4/3/2  AR payload
- arvalid_o  out  1; arready_i  in  1
- rid_i  in  4; rdata_i  in  32; rresp_i  in  2; rlast_i  in  1; rvalid_i  in  1; rready_o  out  1

## Operation
- States: IDLE, AR, R, OUT, DRAIN.
- IDLE: if start_i, latch head_ptr_i & ~32'hF into cur_ptr, clear err_o, and go to AR.
- AR: arvalid_o=1 and araddr_o=cur_ptr. On arvalid_o & arready_i, go to R with beat counter=0.
- Constant AR fields: arlen_o=4'd3, arsize_o=3'd2, arburst_o=2'b01, arid_o=DESC_ARID.
- R: rready_o=1. Each rvalid_i beat stores rdata_i into word[cnt], then cnt increments (2-bit).
- R, normal completion: the beat with cnt==3 and rlast_i=1, with all rresp_i==OKAY, goes to OUT.
- R, error: any rresp_i!=2'b00, rlast_i on beat cnt<3, or cnt==3 without rlast_i sets err_o.
  - If the erroring beat carries rlast_i, go to IDLE; otherwise go to DRAIN.
- rid_i is not checked; only one read is outstanding.
- DRAIN: rready_o=1 and beats are discarded until rlast_i, then go to IDLE. No descriptor is emitted and done_o is not pulsed.
- OUT: desc_valid_o=1 with fields held stable until desc_ready_i. On acceptance:
  - next pointer ==0: pulse done_o and go to IDLE.
  - otherwise: cur_ptr = next & ~32'hF, go to AR.
- A zero desc_len_o is passed through unchanged.
- start_i outside IDLE is ignored.

## Timing
- Reset values:
  - arvalid_o, rready_o, desc_valid_o, busy_o, done_o, err_o: 0.
  - araddr_o and all desc_* fields: 0.
  - Constant AR fields: as listed in Operation.
- arvalid_o asserts the cycle after start_i; araddr_o is stable while arvalid_o=1.
- desc_valid_o asserts the cycle after the 4th R beat and stays high until handshake.
- Chained descriptor: arvalid_o asserts the cycle after the OUT handshake.
- Minimum time per descriptor, zero-wait slave: 1 (AR) + 4 (R) + 1 (OUT) = 6 cycles.
- busy_o falls in the same cycle done_o pulses (the first IDLE cycle is registered). A new start_i is accepted on that cycle or any later one.
- Reset mid-burst discards the burst immediately. The AXI interconnect is reset together with this block.

## Test plan
- Single descriptor: head 0x1000 with words {0x2000, 0x3000, 0x40, 0}.
  - Expect AR addr 0x1000, len 3.
  - Expect desc src 0x2000, dst 0x3000, len 0x40, last=1.
  - Expect done_o pulse; busy_o low after.
- Chain of 3 with desc_ready_i stalled 5 cycles on the 2nd descriptor.
  - Expect ARs at 0x1000, 0x1010, 0x1020 in order.
  - Expect fields held stable during the stall.
  - Expect exactly one done_o.
- Unaligned head 0x100C -> araddr_o=0x1000.
- SLVERR on beat 1 of 4 -> beats 2 and 3 drained, err_o=1, no desc_valid_o, no done_o. A following start_i clears err_o.
- Early rlast_i on beat 2 -> err_o=1, return to IDLE, busy_o=0.
- arready_i delayed 7 cycles and start_i pulsed while busy -> araddr_o stable throughout; the extra start is ignored, with exactly one AR per descriptor.
